// File: rtl/axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_arbiter
// Brief    : Two-requester round-robin arbiter that sequences single read or
//            write transactions onto the seven-segment memory slave.
//            Optional abort timer enabled by defining ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axi_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic [1:0] req_we,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic [1:0] ack,
    output logic       err,
    output logic [7:0] rdata,
    output logic       busy,
    output logic [3:0] m_addr,
    output logic       m_arvalid,
    input  logic       s_arready,
    output logic       m_rready,
    input  logic       s_rvalid,
    input  logic [7:0] s_rdata,
    output logic       m_awvalid,
    input  logic       s_awready,
    output logic       m_wvalid,
    output logic [3:0] m_wdata,
    input  logic       s_wready
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_AR  = 3'd1;
    localparam logic [2:0] S_RD_R   = 3'd2;
    localparam logic [2:0] S_RD_CAP = 3'd3;
    localparam logic [2:0] S_WR_AW  = 3'd4;
    localparam logic [2:0] S_WR_W   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
        $error("axi_arbiter: TIMEOUT must lie in 2..255");
    end

    logic [2:0] state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       grant_q, grant_d;
    logic [3:0] addr_q, addr_d;
    logic [3:0] data_q, data_d;
    logic       flag_q, flag_d;
    logic [1:0] ack_q, ack_d;
    logic       err_q, err_d;
    logic [7:0] rdata_q, rdata_d;
    logic       busy_q, busy_d;
    logic [3:0] m_addr_q, m_addr_d;
    logic [3:0] m_wdata_q, m_wdata_d;
    logic       m_arvalid_q, m_arvalid_d;
    logic       m_rready_q, m_rready_d;
    logic       m_awvalid_q, m_awvalid_d;
    logic       m_wvalid_q, m_wvalid_d;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    logic [7:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        data_d       = data_q;
        flag_d       = flag_q;
        rdata_d      = rdata_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    // On contention the requester that did not win last time goes first
                    grant_d      = (req == 2'b11) ? ~last_grant_q : req[1];
                    last_grant_d = grant_d;
                    addr_d       = grant_d ? req_addr[7:4] : req_addr[3:0];
                    data_d       = grant_d ? req_data[7:4] : req_data[3:0];
`ifdef ARB_TIMEOUT_EN
                    cnt_d        = 8'd0;
`endif
                    if (!req_we[grant_d]) begin
                        state_d = S_RD_AR;
                    end else if (addr_d == 4'd0) begin
                        // Address 0 is read-only: reject without touching the slave
                        state_d = S_DONE;
                        flag_d  = 1'b1;
                    end else begin
                        state_d = S_WR_AW;
                    end
                end
            end
            S_RD_AR:  if (s_arready) state_d = S_RD_R;
            S_RD_R:   if (s_rvalid)  state_d = S_RD_CAP;
            S_RD_CAP: begin
                rdata_d = s_rdata;
                state_d = S_DONE;
            end
            S_WR_AW:  if (s_awready) state_d = S_WR_W;
            S_WR_W:   if (s_wready)  state_d = S_DONE;
            S_DONE: begin
                flag_d  = 1'b0;
                state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
`ifdef ARB_TIMEOUT_EN
        // A stalled handshake that has used up its budget is abandoned
        if (state_q != S_IDLE && state_q != S_DONE) begin
            cnt_d = cnt_q + 8'd1;
            if (state_d == state_q && cnt_d == TIMEOUT_C) begin
                state_d = S_DONE;
                flag_d  = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        busy_d      = (state_d != S_IDLE);
        ack_d       = (state_d == S_DONE) ? (grant_d ? 2'b10 : 2'b01) : 2'b00;
        err_d       = (state_d == S_DONE) && flag_d;
        m_addr_d    = busy_d ? addr_d : 4'd0;
        m_wdata_d   = busy_d ? data_d : 4'd0;
        m_arvalid_d = (state_d == S_RD_AR) || (state_d == S_RD_R);
        m_rready_d  = (state_d == S_RD_R);
        m_awvalid_d = (state_d == S_WR_AW) || (state_d == S_WR_W);
        m_wvalid_d  = (state_d == S_WR_W);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            addr_q       <= 4'd0;
            data_q       <= 4'd0;
            flag_q       <= 1'b0;
            ack_q        <= 2'b00;
            err_q        <= 1'b0;
            rdata_q      <= 8'd0;
            busy_q       <= 1'b0;
            m_addr_q     <= 4'd0;
            m_wdata_q    <= 4'd0;
            m_arvalid_q  <= 1'b0;
            m_rready_q   <= 1'b0;
            m_awvalid_q  <= 1'b0;
            m_wvalid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            flag_q       <= flag_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_arvalid_q  <= m_arvalid_d;
            m_rready_q   <= m_rready_d;
            m_awvalid_q  <= m_awvalid_d;
            m_wvalid_q   <= m_wvalid_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign ack       = ack_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_arvalid = m_arvalid_q;
    assign m_rready  = m_rready_q;
    assign m_awvalid = m_awvalid_q;
    assign m_wvalid  = m_wvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_axi_arbiter
// Brief    : Self-checking bench for axi_arbiter: directed vector table,
//            corner-case sequences and a randomized transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] req, req_we;
    logic [7:0] req_addr, req_data;
    logic [1:0] ack;
    logic       err;
    logic [7:0] rdata;
    logic       busy;
    logic [3:0] m_addr, m_wdata;
    logic       m_arvalid, s_arready, m_rready, s_rvalid;
    logic [7:0] s_rdata;
    logic       m_awvalid, s_awready, m_wvalid, s_wready;

    always #5 clk = ~clk;

    axi_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req(req), .req_we(req_we), .req_addr(req_addr), .req_data(req_data),
        .ack(ack), .err(err), .rdata(rdata), .busy(busy),
        .m_addr(m_addr), .m_arvalid(m_arvalid), .s_arready(s_arready),
        .m_rready(m_rready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .m_awvalid(m_awvalid), .s_awready(s_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .s_wready(s_wready)
    );

    typedef struct {
        bit         who;
        bit         we;
        logic [3:0] addr;
        logic [3:0] data;
        bit         preset;
        logic [7:0] mem_val;
        logic [1:0] exp_ack;
        bit         exp_err;
        logic [7:0] exp_rdata;
        int         exp_cycles;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] slave_mem [16];
    logic [7:0] model_mem [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] all_outputs();
        return {ack, err, rdata, busy, m_addr, m_arvalid, m_rready, m_awvalid, m_wvalid, m_wdata};
    endfunction

    // One clock: slave side reacts to handshakes seen at this edge
    task automatic step();
        logic       hs_r, hs_w;
        logic [3:0] a, d;
        hs_r = m_rready && s_rvalid;
        hs_w = m_wvalid && s_wready;
        a    = m_addr;
        d    = m_wdata;
        @(posedge clk);
        #1;
        if (hs_r) s_rdata = slave_mem[a];
        if (hs_w) slave_mem[a] = {~d, d};
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int         n;
        bit         seen, bad_hold, bad_aw;
        logic [1:0] got_ack;
        logic       got_err;
        logic [7:0] got_rd;
        n = 0; seen = 0; bad_hold = 0; bad_aw = 0;
        got_ack = 2'b00; got_err = 1'b0; got_rd = 8'h00;
        if (v.preset) slave_mem[v.addr] = v.mem_val;
        req      = v.who ? 2'b10 : 2'b01;
        req_we   = {v.we, v.we};
        req_addr = {v.addr, v.addr};
        req_data = {v.data, v.data};
        while (!seen && n < 20) begin
            step();
            n++;
            if (n == 1) begin
                req_addr = ~req_addr;
                req_data = ~req_data;
            end
            if (busy && (m_addr !== v.addr || m_wdata !== v.data)) bad_hold = 1;
            if (m_awvalid && v.we && v.addr == 4'd0) bad_aw = 1;
            if (ack !== 2'b00) begin
                seen    = 1;
                got_ack = ack;
                got_err = err;
                got_rd  = rdata;
            end
        end
        req = 2'b00;
        check($sformatf("vec%0d_ack", idx), got_ack, v.exp_ack);
        check($sformatf("vec%0d_err", idx), got_err, v.exp_err);
        check($sformatf("vec%0d_rdata", idx), got_rd, v.exp_rdata);
        check($sformatf("vec%0d_cycles", idx), n + 1, v.exp_cycles);
        check($sformatf("vec%0d_hold", idx), {bad_hold, bad_aw}, 2'b00);
        step();
        check($sformatf("vec%0d_ack_pulse", idx), {ack, busy}, 3'b000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       vt [8];
        logic [1:0] acks [4];
        int         at [4];
        logic [7:0] rds [4];
        int         k, n;
        bit         acked, seen;

        vt[0] = '{1'b1, 1'b0, 4'd5,  4'd0, 1'b1, 8'h49, 2'b10, 1'b0, 8'h49, 5};
        vt[1] = '{1'b0, 1'b1, 4'd3,  4'd7, 1'b0, 8'h00, 2'b01, 1'b0, 8'h49, 4};
        vt[2] = '{1'b0, 1'b0, 4'd3,  4'd0, 1'b0, 8'h00, 2'b01, 1'b0, 8'h87, 5};
        vt[3] = '{1'b1, 1'b1, 4'd0,  4'd9, 1'b0, 8'h00, 2'b10, 1'b1, 8'h87, 2};
        vt[4] = '{1'b1, 1'b0, 4'd0,  4'd0, 1'b1, 8'h3F, 2'b10, 1'b0, 8'h3F, 5};
        vt[5] = '{1'b0, 1'b1, 4'd15, 4'hA, 1'b0, 8'h00, 2'b01, 1'b0, 8'h3F, 4};
        vt[6] = '{1'b1, 1'b0, 4'd15, 4'd0, 1'b0, 8'h00, 2'b10, 1'b0, 8'h5A, 5};
        vt[7] = '{1'b0, 1'b1, 4'd0,  4'd0, 1'b0, 8'h00, 2'b01, 1'b1, 8'h5A, 2};

        for (int i = 0; i < 16; i++) slave_mem[i] = 8'($urandom);
        slave_mem[2] = 8'h12;
        slave_mem[9] = 8'h99;
        reset_n   = 1'b0;
        req       = 2'b11;
        req_we    = 2'b00;
        req_addr  = {4'd9, 4'd2};
        req_data  = 8'h00;
        s_arready = 1'b1; s_rvalid = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        s_rdata   = 8'h00;

        // Reset with both requesting, then strict alternation starting at requester 0
        step(); step();
        check("reset_outputs", all_outputs(), 24'h0);
        reset_n = 1'b1;
        k = 0; n = 0;
        for (int i = 0; i < 4; i++) begin acks[i] = 2'b00; at[i] = 0; rds[i] = 8'h00; end
        while (k < 4 && n < 40) begin
            step();
            n++;
            if (ack !== 2'b00) begin
                acks[k] = ack; at[k] = n; rds[k] = rdata;
                k++;
                if (k == 4) req = 2'b00;
            end
        end
        check("alt_count", k, 4);
        check("alt_first_latency", at[0], 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("alt%0d_ack", i), acks[i], (i % 2) ? 2'b10 : 2'b01);
            check($sformatf("alt%0d_rdata", i), rds[i], (i % 2) ? 8'h99 : 8'h12);
            if (i > 0) check($sformatf("alt%0d_gap", i), at[i] - at[i-1], 5);
        end
        step(); step();
        check("alt_idle", busy, 1'b0);

        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        // Reset while stalled in the read-data phase
        s_rvalid = 1'b0;
        slave_mem[4] = 8'hC4;
        req = 2'b01; req_we = 2'b00; req_addr = 8'h04; req_data = 8'h00;
        step(); step();
        check("rst_in_rd_r", {m_arvalid, m_rready}, 2'b11);
        check("rst_pre_rdata", rdata, 8'h5A);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_outputs", all_outputs(), 24'h0);
        acked = 0;
        repeat (3) begin
            step();
            if (ack !== 2'b00) acked = 1;
        end
        check("rst_no_ack", acked, 1'b0);
        reset_n = 1'b1;
        s_rvalid = 1'b1;
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            step();
            n++;
            if (ack !== 2'b00) seen = 1;
        end
        check("rst_after_ack", ack, 2'b01);
        check("rst_after_rdata", rdata, 8'hC4);
        check("rst_after_cycles", n + 1, 5);
        req = 2'b00;
        step();

`ifdef ARB_TIMEOUT_EN
        s_arready = 1'b0;
        req = 2'b10; req_we = 2'b00; req_addr = 8'h60;
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            step();
            n++;
            if (ack !== 2'b00) seen = 1;
        end
        check("to_ack", ack, 2'b10);
        check("to_err", err, 1'b1);
        check("to_rdata", rdata, 8'hC4);
        check("to_valids", {m_arvalid, m_rready, m_awvalid, m_wvalid}, 4'h0);
        req = 2'b00; s_arready = 1'b1;
        step();
`endif

        // Randomized traffic against a transaction-level model
        reset_n = 1'b0;
        step();
        check("reset2_outputs", all_outputs(), 24'h0);
        reset_n = 1'b1;
        begin
            logic [1:0] pend;
            bit         pw [2];
            logic [3:0] pa [2], pd [2];
            bit         in_flight, cool, winner, m_last, abort, allow;
            logic [7:0] m_rdata;
            int         m_wait;
            pend = 2'b00; in_flight = 0; cool = 0; winner = 0; m_last = 1; abort = 0;
            m_rdata = 8'h00; m_wait = 0;
            for (int i = 0; i < 2; i++) begin pw[i] = 0; pa[i] = 4'd0; pd[i] = 4'd0; end
            model_mem = slave_mem;
            for (int cyc = 0; cyc < 3000 && !abort; cyc++) begin
                for (int i = 0; i < 2; i++) begin
                    if (!pend[i] && $urandom_range(0, 2) == 0) begin
                        pend[i] = 1'b1;
                        pw[i]   = 1'($urandom_range(0, 1));
                        pa[i]   = 4'($urandom_range(0, 15));
                        pd[i]   = 4'($urandom_range(0, 15));
                    end
                end
                req      = pend;
                req_we   = {pw[1], pw[0]};
                req_addr = {pa[1], pa[0]};
                req_data = {pd[1], pd[0]};
`ifdef ARB_TIMEOUT_EN
                s_arready = 1'b1; s_rvalid = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
`else
                s_arready = ($urandom_range(0, 3) != 0);
                s_rvalid  = ($urandom_range(0, 3) != 0);
                s_awready = ($urandom_range(0, 3) != 0);
                s_wready  = ($urandom_range(0, 3) != 0);
`endif
                allow = !in_flight && !cool;
                cool  = 0;
                if (allow && pend != 2'b00) begin
                    winner    = (pend == 2'b11) ? !m_last : pend[1];
                    m_last    = winner;
                    in_flight = 1;
                    m_wait    = 0;
                end
                step();
                if (in_flight) begin
                    m_wait++;
                    if (ack !== 2'b00) begin
                        check("rnd_ack", ack, winner ? 2'b10 : 2'b01);
                        check("rnd_err", err, pw[winner] && pa[winner] == 4'd0);
                        if (!pw[winner]) m_rdata = model_mem[pa[winner]];
                        else if (pa[winner] != 4'd0) model_mem[pa[winner]] = {~pd[winner], pd[winner]};
                        pend[winner] = 1'b0;
                        in_flight    = 0;
                        cool         = 1;
                    end else if (m_wait > 100) begin
                        checks++;
                        errors++;
                        $display("FAIL rnd_latency: no ack after %0d cycles, required within 100", m_wait);
                        abort = 1;
                    end
                end else begin
                    check("rnd_idle_ack", ack, 2'b00);
                end
                check("rnd_rdata", rdata, m_rdata);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
